// File: rtl/frame_write_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : frame_write_ctrl_if
//  Purpose  : Bundles the rasterizer pixel stream and the frame-memory write
//             bus used by frame_write_ctrl.
//  Signals  :
//    frame_rd_en  pixel valid strobe (rasterizer -> ctrl)
//    frame_x/y    pixel coordinates
//    px_color     pixel color
//    raster_done  one-cycle end-of-frame pulse
//    frame_ready  ctrl may accept a pixel next cycle (ctrl -> rasterizer)
//    mem_addr     {back-buffer select, linear address} (ctrl -> memory)
//    mem_wdata    write color
//    mem_we       write request, held until mem_ack
//    mem_ack      write accepted this cycle (memory -> ctrl)
//  Modports : master = rasterizer + memory side, slave = frame_write_ctrl
//  Revision : 1.0  initial release
// ============================================================================
interface frame_write_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic              frame_rd_en;
  logic [9:0]        frame_x;
  logic [8:0]        frame_y;
  logic [2:0]        px_color;
  logic              raster_done;
  logic              frame_ready;
  logic [ADDR_W:0]   mem_addr;
  logic [2:0]        mem_wdata;
  logic              mem_we;
  logic              mem_ack;

  modport master (
    output frame_rd_en, frame_x, frame_y, px_color, raster_done, mem_ack,
    input  frame_ready, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  frame_rd_en, frame_x, frame_y, px_color, raster_done, mem_ack,
    output frame_ready, mem_addr, mem_wdata, mem_we
  );
endinterface
`default_nettype wire

// File: rtl/frame_write_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : frame_write_ctrl
//  Purpose  : Accepts the rasterizer pixel stream into a small FIFO, converts
//             (x,y) to a linear address in the back half of a double-buffered
//             frame memory and writes it with a we/ack handshake. At end of
//             frame it drains the FIFO, swaps front/back buffers and, when
//             CLEAR_ON_SWAP_EN is defined, fills the new back buffer with
//             bk_color.
//  Ports    :
//    clk         system clock, rising edge
//    rst         asynchronous active-low reset
//    bus         frame_write_ctrl_if.slave (pixel stream + memory bus)
//    bk_color    clear color (only used with CLEAR_ON_SWAP_EN)
//    buf_sel     front (displayed) buffer index
//    frame_swap  one-cycle pulse while the buffers swap
//    err_ovf     sticky: in-range pixel dropped on a full FIFO
//  Options  : `define CLEAR_ON_SWAP_EN to enable the post-swap clear pass
//  Revision : 1.0  initial release
// ============================================================================
module frame_write_ctrl #(
  parameter int DEPTH  = 8,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic                clk,
  input  logic                rst,
  frame_write_ctrl_if.slave   bus,
  input  logic [2:0]          bk_color,
  output logic                buf_sel,
  output logic                frame_swap,
  output logic                err_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 10 + 9 + 3;

  localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_READY_MAX = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE       = PTR_W'(1);
`ifdef CLEAR_ON_SWAP_EN
  localparam logic [ADDR_W-1:0] CLR_LAST     = ADDR_W'(H_RES * V_RES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
`ifdef CLEAR_ON_SWAP_EN
    ST_CLEAR = 2'd3,
`endif
    ST_SWAP  = 2'd2
  } state_t;

  state_t            state, state_nx;

  logic [ENT_W-1:0]  fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              done_pend;

  logic              in_range;
  logic              push, pop, drop;
  logic [9:0]        head_x;
  logic [8:0]        head_y;
  logic [2:0]        head_color;
  logic [ADDR_W-1:0] pix_addr;

`ifdef CLEAR_ON_SWAP_EN
  logic [ADDR_W-1:0] clr_cnt;
`else
  // Clear color has no consumer when the clear pass is compiled out.
  logic              unused_bk_color;
  assign unused_bk_color = ^bk_color;
`endif

  // --------------------------------------------------------------------------
  // Input filter and FIFO control
  // --------------------------------------------------------------------------
  // Off-screen pixels vanish here: never stored and never counted as overflow.
  assign in_range = ({22'd0, bus.frame_x} < H_RES) && ({23'd0, bus.frame_y} < V_RES);

  // A full FIFO refuses the strobe even if a pop happens in the same cycle;
  // frame_ready already gave the rasterizer a cycle of warning.
  assign push = bus.frame_rd_en && in_range && (count != CNT_FULL);
  assign drop = bus.frame_rd_en && in_range && (count == CNT_FULL);
  assign pop  = (state == ST_WRITE) && bus.mem_ack;

  // Registered count leaves room for one strobe already in flight.
  assign bus.frame_ready = (count <= CNT_READY_MAX);

  assign head_x     = fifo_mem[rd_ptr][21:12];
  assign head_y     = fifo_mem[rd_ptr][11:3];
  assign head_color = fifo_mem[rd_ptr][2:0];

  // Full-width product: y*H_RES + x fits ADDR_W bits for every on-screen pixel.
  assign pix_addr = ADDR_W'(head_y) * ADDR_W'(H_RES) + ADDR_W'(head_x);

  // Pixel storage carries no reset; emptiness is tracked by pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.frame_x, bus.frame_y, bus.px_color};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame bookkeeping: pending end-of-frame, buffer select, overflow flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_pend <= 1'b0;
      buf_sel   <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      // A new end-of-frame arriving during the swap cycle belongs to the
      // next frame, so setting wins over the swap's clear.
      if (bus.raster_done)       done_pend <= 1'b1;
      else if (state == ST_SWAP) done_pend <= 1'b0;

      if (state == ST_SWAP) buf_sel <= ~buf_sel;
      if (drop)             err_ovf <= 1'b1;
    end
  end

`ifdef CLEAR_ON_SWAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_cnt <= '0;
    end else if (state == ST_SWAP) begin
      clr_cnt <= '0;
    end else if ((state == ST_CLEAR) && bus.mem_ack) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {~buf_sel, pix_addr};
    bus.mem_wdata = head_color;
    frame_swap    = 1'b0;

    case (state)
      ST_IDLE: begin
        // Pending pixels are finished before the frame is allowed to swap.
        if (count != '0)    state_nx = ST_WRITE;
        else if (done_pend) state_nx = ST_SWAP;
      end

      ST_WRITE: begin
        bus.mem_we = 1'b1;
        if (bus.mem_ack) begin
          // Something left after this pop (counting a same-cycle push) keeps
          // the write stream going at one pixel per cycle.
          if ((count > CNT_ONE) || push) state_nx = ST_WRITE;
          else                            state_nx = ST_IDLE;
        end
      end

      ST_SWAP: begin
        frame_swap = 1'b1;
`ifdef CLEAR_ON_SWAP_EN
        state_nx   = ST_CLEAR;
`else
        state_nx   = ST_IDLE;
`endif
      end

`ifdef CLEAR_ON_SWAP_EN
      ST_CLEAR: begin
        // buf_sel has already toggled, so ~buf_sel is the new back buffer.
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {~buf_sel, clr_cnt};
        bus.mem_wdata = bk_color;
        if (bus.mem_ack && (clr_cnt == CLR_LAST)) state_nx = ST_IDLE;
      end
`endif

      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_write_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_frame_write_ctrl
//  Purpose  : Directed bench for frame_write_ctrl. Stimulus pushes expected
//             memory writes and swap events into a scoreboard queue; a monitor
//             pops and compares whenever the DUT performs an acked write or
//             pulses frame_swap.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frame_write_ctrl;

`ifdef CLEAR_ON_SWAP_EN
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int AW = 7;
`else
  localparam int H  = 640;
  localparam int V  = 480;
  localparam int AW = 19;
`endif

  typedef struct packed {
    logic          is_swap;
    logic [AW:0]   addr;
    logic [2:0]    data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] bk_color;
  logic       buf_sel;
  logic       frame_swap;
  logic       err_ovf;

  frame_write_ctrl_if #(.ADDR_W(AW)) bus ();

  frame_write_ctrl #(
    .DEPTH  (8),
    .H_RES  (H),
    .V_RES  (V),
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .bk_color   (bk_color),
    .buf_sel    (buf_sel),
    .frame_swap (frame_swap),
    .err_ovf    (err_ovf)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   swap_seen = 0;
  logic exp_buf   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic is_swap, input logic [AW:0] addr, input logic [2:0] data);
    exp_t e;
    e.is_swap = is_swap;
    e.addr    = addr;
    e.data    = data;
    return e;
  endfunction

  function automatic logic [AW-1:0] lin(input int x, input int y);
    return AW'(y * H + x);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      if (bus.mem_we && bus.mem_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_write", {1'b0, bus.mem_addr}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("wr_not_swap", 32'(e.is_swap), 32'd0);
          check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
          check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
        end
      end
      if (frame_swap) begin
        swap_seen++;
        if (sb.size() == 0) begin
          check("unexpected_swap", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("swap_order", 32'(e.is_swap), 32'd1);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_swap();
    sb.push_back(mk(1'b1, '0, 3'd0));
    exp_buf = ~exp_buf;
`ifdef CLEAR_ON_SWAP_EN
    for (int i = 0; i < H * V; i++) sb.push_back(mk(1'b0, {~exp_buf, AW'(i)}, bk_color));
`endif
  endtask

  task automatic send(input int x, input int y, input logic [2:0] c, input logic done, input logic enq);
    step();
    bus.frame_rd_en = 1'b1;
    bus.frame_x     = 10'(x);
    bus.frame_y     = 9'(y);
    bus.px_color    = c;
    bus.raster_done = done;
    if (enq)  sb.push_back(mk(1'b0, {~exp_buf, lin(x, y)}, c));
    if (done) push_swap();
  endtask

  task automatic idle();
    step();
    bus.frame_rd_en = 1'b0;
    bus.raster_done = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    check(name, 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic async_reset();
    rst = 1'b0;
    #1;
    check("rst_we_async", 32'(bus.mem_we), 32'd0);
    sb.delete();
    exp_buf = 1'b0;
    check("rst_buf_sel", 32'(buf_sel), 32'd0);
    check("rst_err_ovf", 32'(err_ovf), 32'd0);
    step();
    rst = 1'b1;
    check("rst_ready", 32'(bus.frame_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst             = 1'b0;
    bk_color        = 3'd6;
    bus.frame_rd_en = 1'b0;
    bus.frame_x     = '0;
    bus.frame_y     = '0;
    bus.px_color    = '0;
    bus.raster_done = 1'b0;
    bus.mem_ack     = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_we",    32'(bus.mem_we),      32'd0);
    check("reset_ready", 32'(bus.frame_ready), 32'd1);
    check("reset_buf",   32'(buf_sel),         32'd0);
    check("reset_ovf",   32'(err_ovf),         32'd0);
    check("reset_swap",  32'(frame_swap),      32'd0);
    rst = 1'b1;

    // Single pixel (3,2) color 5: address 2*H+3 (1283 at 640 wide), MSB 1.
    send(3, 2, 3'd5, 1'b0, 1'b1);
    idle();
    check("t1_ready", 32'(bus.frame_ready), 32'd1);
    wait_drain("t1_drain", 20);
    check("t1_buf", 32'(buf_sel), 32'd0);

    // Off-screen pixels are filtered out.
    send(H, 0, 3'd1, 1'b0, 1'b0);
    send(0, V, 3'd2, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_no_we", 32'(bus.mem_we), 32'd0);
    end
    check("t3_ovf", 32'(err_ovf), 32'd0);

    // Fill the FIFO with ack held low, then overflow it.
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(i, 1, 3'(i), 1'b0, 1'b1);
      if (i > 0) check("t2_ready", 32'(bus.frame_ready), (i <= 6) ? 32'd1 : 32'd0);
    end
    send(8, 1, 3'd1, 1'b0, 1'b0);
    check("t2_ready_full", 32'(bus.frame_ready), 32'd0);
    idle();
    check("t2_ovf", 32'(err_ovf), 32'd1);
    check("t2_we_hold", 32'(bus.mem_we), 32'd1);
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t2_back2back", 32'(bus.mem_we), 32'd1);
    end
    @(negedge clk);
    check("t2_we_done", 32'(bus.mem_we), 32'd0);
    wait_drain("t2_drain", 20);

    // Two pixels, end-of-frame with the second; swap only after both writes.
    send(10, 5, 3'd1, 1'b0, 1'b1);
    send(11, 5, 3'd2, 1'b1, 1'b1);
    idle();
`ifdef CLEAR_ON_SWAP_EN
    for (int i = 0; i < 200; i++) begin
      if (sb.size() <= 100) break;
      @(posedge clk);
    end
    send(1, 1, 3'd3, 1'b0, 1'b1);
    idle();
    wait_drain("t4_clear_drain", 400);
`else
    wait_drain("t4_drain", 30);
`endif
    check("t4_swaps", 32'(swap_seen), 32'd1);
    check("t4_buf", 32'(buf_sel), 32'd1);
    send(5, 0, 3'd7, 1'b0, 1'b1);
    idle();
    wait_drain("t4_post_drain", 20);

    // Reset while a write is held waiting for ack.
    bus.mem_ack = 1'b0;
    send(2, 2, 3'd4, 1'b0, 1'b1);
    idle();
    step();
    check("t5_we_before", 32'(bus.mem_we), 32'd1);
    #2;
    async_reset();
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_no_we", 32'(bus.mem_we), 32'd0);
    end

`ifdef CLEAR_ON_SWAP_EN
    // Reset in the middle of a clear pass at clr_cnt == 3.
    swap_seen = 0;
    step();
    bus.raster_done = 1'b1;
    push_swap();
    idle();
    for (int i = 0; i < 20; i++) begin
      if (swap_seen == 1) break;
      @(posedge clk);
    end
    check("t6_swap_seen", 32'(swap_seen), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    check("t6_we_clear", 32'(bus.mem_we), 32'd1);
    async_reset();
    send(4, 3, 3'd2, 1'b0, 1'b1);
    idle();
    wait_drain("t6_drain", 20);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
